// File: rtl/cmd_fifo.sv
// Command queue between UART_wrapper and cmd_proc: captures commands on the cmd_rdy/clr_cmd_rdy handshake and replays them in order.
// Optional feature macro CMD_FIFO_FLUSH_EN adds a flush input that empties the queue on the next edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef CMD_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [WIDTH-1:0]           in_cmd,
  input  logic                       in_rdy,
  output logic                       in_clr,
  output logic [WIDTH-1:0]           cmd,
  output logic                       cmd_rdy,
  input  logic                       clr_cmd_rdy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAITLO
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_cmd_rdy;
  logic             r_full;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [CW-1:0]    w_count_nxt;

`ifdef CMD_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Registered full gates capture, so a pop while full costs one bubble cycle.
  assign w_push      = (r_state == S_IDLE) && in_rdy && !r_full;
  assign w_pop       = clr_cmd_rdy && r_cmd_rdy;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    in_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_push) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        in_clr      = 1'b1;
        w_state_nxt = S_WAITLO;
      end
      S_WAITLO: begin
        // Hold off until the wrapper drops cmd_rdy so one command is never taken twice.
        if (!in_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cmd_rdy <= 1'b0;
      r_full    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_cmd_rdy <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_cmd;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count   <= w_count_nxt;
      r_cmd_rdy <= (w_count_nxt != '0);
      r_full    <= (w_count_nxt == CNT_FULL);
    end
  end

  assign cmd     = r_mem[r_rd_ptr];
  assign cmd_rdy = r_cmd_rdy;
  assign count   = r_count;
  assign full    = r_full;

endmodule

// File: tb/tb_cmd_fifo.sv
// Self-checking bench for cmd_fifo: vector table, directed corner sequences, and a randomized run against a queue model.
module tb_cmd_fifo;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_cmd;
  logic             in_rdy;
  logic             in_clr;
  logic [WIDTH-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic [2:0]       count;
  logic             full;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CMD_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .in_cmd(in_cmd),
    .in_rdy(in_rdy),
    .in_clr(in_clr),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .count(count),
    .full(full)
  );

  typedef struct {
    logic        rdy;
    logic [15:0] din;
    logic        clr;
    logic        e_clr;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        chk_cmd;
    logic [15:0] e_cmd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rdy, logic [15:0] din, logic clr, logic e_clr, logic e_rdy,
                              logic [2:0] e_cnt, logic e_full, logic chk_cmd, logic [15:0] e_cmd);
    vec_t v;
    v.rdy = rdy; v.din = din; v.clr = clr; v.e_clr = e_clr; v.e_rdy = e_rdy;
    v.e_cnt = e_cnt; v.e_full = e_full; v.chk_cmd = chk_cmd; v.e_cmd = e_cmd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] v);
    logic got;
    got = 1'b0;
    in_cmd = v;
    in_rdy = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      if (in_clr) got = 1'b1;
    end
    chk($sformatf("push_ack_%h", v), {31'd0, got}, 32'd1);
    in_rdy = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_chk(input logic [15:0] exp);
    chk($sformatf("pop_cmd_%h", exp), {16'd0, cmd}, {16'd0, exp});
    chk("pop_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] rq[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_cmd = '0; in_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    #3;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_in_clr", {31'd0, in_clr}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    tick();
    rst = 1'b0;

    // single push, then fill-to-full with blocked fifth push and drain
    vt.push_back(mk(1, 16'h2000, 0, 1, 1, 1, 0, 1, 16'h2000));
    vt.push_back(mk(0, 16'h2000, 0, 0, 1, 1, 0, 1, 16'h2000));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    vt.push_back(mk(1, 16'h4001, 0, 1, 1, 1, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h4001));
    vt.push_back(mk(1, 16'h4002, 0, 1, 1, 2, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 2, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 2, 0, 1, 16'h4001));
    vt.push_back(mk(1, 16'h4003, 0, 1, 1, 3, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 3, 0, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 3, 0, 1, 16'h4001));
    vt.push_back(mk(1, 16'h4004, 0, 1, 1, 4, 1, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 4, 1, 1, 16'h4001));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 4, 1, 1, 16'h4001));
    vt.push_back(mk(1, 16'h5005, 0, 0, 1, 4, 1, 1, 16'h4001));
    vt.push_back(mk(1, 16'h5005, 0, 0, 1, 4, 1, 1, 16'h4001));
    vt.push_back(mk(1, 16'h5005, 1, 0, 1, 3, 0, 1, 16'h4002));
    vt.push_back(mk(1, 16'h5005, 0, 1, 1, 4, 1, 1, 16'h4002));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 4, 1, 1, 16'h4002));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 4, 1, 1, 16'h4002));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 3, 0, 1, 16'h4003));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 2, 0, 1, 16'h4004));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 0, 1, 16'h5005));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));

    for (int i = 0; i < vt.size(); i++) begin
      in_rdy = vt[i].rdy; in_cmd = vt[i].din; clr_cmd_rdy = vt[i].clr;
      tick();
      chk($sformatf("v%0d_in_clr", i), {31'd0, in_clr}, {31'd0, vt[i].e_clr});
      chk($sformatf("v%0d_cmd_rdy", i), {31'd0, cmd_rdy}, {31'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vt[i].e_cnt});
      chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, vt[i].e_full});
      if (vt[i].chk_cmd) chk($sformatf("v%0d_cmd", i), {16'd0, cmd}, {16'd0, vt[i].e_cmd});
    end
    in_rdy = 1'b0; clr_cmd_rdy = 1'b0;

    // slow wrapper: in_rdy held six cycles past the ack
    in_cmd = 16'h1234; in_rdy = 1'b1;
    tick();
    chk("slow_ack", {31'd0, in_clr}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("slow_noack%0d", k), {31'd0, in_clr}, 32'd0);
      chk($sformatf("slow_count%0d", k), {29'd0, count}, 32'd1);
    end
    in_rdy = 1'b0;
    tick(); tick();
    chk("slow_count_end", {29'd0, count}, 32'd1);
    pop_chk(16'h1234);

    // simultaneous push and pop at count=2
    push_cmd(16'h0A01);
    push_cmd(16'h0A02);
    chk("pp_count_pre", {29'd0, count}, 32'd2);
    in_cmd = 16'h0A03; in_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0; in_rdy = 1'b0;
    chk("pp_ack", {31'd0, in_clr}, 32'd1);
    chk("pp_count", {29'd0, count}, 32'd2);
    chk("pp_cmd", {16'd0, cmd}, 32'h0A02);
    tick(); tick();
    pop_chk(16'h0A02);
    pop_chk(16'h0A03);

    // ten commands through the queue for pointer wrap
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      push_cmd(16'h0B00 + 16'(i));
      exp_q.push_back(16'h0B00 + 16'(i));
      if (i >= 2) pop_chk(exp_q.pop_front());
    end
    while (exp_q.size() > 0) pop_chk(exp_q.pop_front());
    chk("wrap_empty", {29'd0, count}, 32'd0);

    // async reset during ACK with three queued
    push_cmd(16'h0C01);
    push_cmd(16'h0C02);
    in_cmd = 16'h0C03; in_rdy = 1'b1;
    tick();
    chk("ar_pre_ack", {31'd0, in_clr}, 32'd1);
    chk("ar_pre_count", {29'd0, count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_in_clr", {31'd0, in_clr}, 32'd0);
    chk("ar_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("ar_count", {29'd0, count}, 32'd0);
    chk("ar_full", {31'd0, full}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_recap_ack", {31'd0, in_clr}, 32'd1);
    chk("ar_recap_count", {29'd0, count}, 32'd1);
    chk("ar_recap_cmd", {16'd0, cmd}, 32'h0C03);
    in_rdy = 1'b0;
    tick(); tick();
    pop_chk(16'h0C03);
    clr_cmd_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("empty_pop_count%0d", k), {29'd0, count}, 32'd0);
      chk($sformatf("empty_pop_rdy%0d", k), {31'd0, cmd_rdy}, 32'd0);
    end
    clr_cmd_rdy = 1'b0;

`ifdef CMD_FIFO_FLUSH_EN
    push_cmd(16'h0D01);
    push_cmd(16'h0D02);
    push_cmd(16'h0D03);
    chk("fl_pre_count", {29'd0, count}, 32'd3);
    flush = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    flush = 1'b0; clr_cmd_rdy = 1'b0;
    chk("fl_count", {29'd0, count}, 32'd0);
    chk("fl_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    push_cmd(16'h4005);
    chk("fl_after_cmd", {16'd0, cmd}, 32'h4005);
    chk("fl_after_count", {29'd0, count}, 32'd1);
    pop_chk(16'h4005);
`endif

    // randomized run: wrapper model with random hold times, random pops, queue reference
    begin
      int ust;       // 0 idle, 1 offering, 2 holding after ack, 3 gap
      int hold;
      int waitc;
      int n_off;
      int n_ack;
      logic pop_now;
      logic full_before;
      ust = 0; hold = 0; waitc = 0; n_off = 0; n_ack = 0;
      rq.delete();
      for (int cyc = 0; cyc < 900; cyc++) begin
        logic drain;
        drain = (cyc >= 700);
        full_before = (rq.size() == DEPTH);
        pop_now = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
        clr_cmd_rdy = pop_now;
        if (pop_now && rq.size() > 0) begin
          chk("rnd_pop_cmd", {16'd0, cmd}, {16'd0, rq[0]});
          void'(rq.pop_front());
        end
        case (ust)
          0: if (!drain && $urandom_range(0, 3) == 0) begin
               in_cmd = 16'($urandom); in_rdy = 1'b1; ust = 1; waitc = 0; n_off++;
             end
          2: if (hold == 0) begin in_rdy = 1'b0; ust = 3; hold = 2; end
             else hold--;
          3: begin hold--; if (hold == 0) ust = 0; end
          default: ;
        endcase
        tick();
        if (in_clr) begin
          chk("rnd_ack_expected", {31'd0, (ust == 1)}, 32'd1);
          chk("rnd_ack_not_full", {31'd0, full_before}, 32'd0);
          if (ust == 1) begin
            rq.push_back(in_cmd);
            n_ack++;
            ust = 2;
            hold = $urandom_range(0, 3);
          end
        end else if (ust == 1) begin
          waitc++;
          if (waitc > 100) begin
            chk("rnd_ack_timeout", 32'(waitc), 32'd0);
            in_rdy = 1'b0; ust = 3; hold = 2;
          end
        end
        chk("rnd_count", {29'd0, count}, 32'(rq.size()));
        chk("rnd_cmd_rdy", {31'd0, cmd_rdy}, {31'd0, (rq.size() != 0)});
        chk("rnd_full", {31'd0, full}, {31'd0, (rq.size() == DEPTH)});
        if (rq.size() > 0) chk("rnd_head", {16'd0, cmd}, {16'd0, rq[0]});
      end
      clr_cmd_rdy = 1'b0;
      in_rdy = 1'b0;
      chk("rnd_all_acked", 32'(n_ack), 32'(n_off));
      chk("rnd_model_empty", 32'(rq.size()), 32'd0);
      chk("rnd_final_count", {29'd0, count}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmd_fifo.md
Name: cmd_fifo

Overview:
- Command queue between UART_wrapper (upstream) and cmd_proc (downstream).
- Accepts assembled 16-bit commands using UART_wrapper's cmd/cmd_rdy/clr_cmd_rdy handshake.
- Buffers up to DEPTH commands and re-presents them to cmd_proc on the same style of handshake. The host can therefore queue a tour of moves while cmd_proc is still executing the current one.

Parameters:
- DEPTH, 4, number of command entries; power of 2, minimum 2.
- WIDTH, 16, command width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_cmd  in  WIDTH  command from UART_wrapper
- in_rdy  in  1  UART_wrapper cmd_rdy; stays high until cleared
- in_clr  out  1  one-cycle clear pulse to UART_wrapper clr_cmd_rdy
- cmd  out  WIDTH  head-of-queue command to cmd_proc
- cmd_rdy  out  1  queue non-empty
- clr_cmd_rdy  in  1  pop request from cmd_proc
- count  out  $clog2(DEPTH)+1  entries held
- full  out  1  count == DEPTH

Behaviour:
- Reset (async, rst=1): pointers=0, count=0, cmd=0, cmd_rdy=0, in_clr=0, full=0, ingress FSM=IDLE. Memory contents are don't-care.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0 naturally.
- Ingress FSM:
  - IDLE: if in_rdy && !full, write in_cmd at wr_ptr, increment wr_ptr, go to ACK. Otherwise stay.
  - ACK: in_clr=1 for exactly this cycle, go to WAITLO.
  - WAITLO: stay until in_rdy==0, then go to IDLE. This prevents double-capture of one command.
- While full, in_rdy is left pending and in_clr is not asserted. Capture resumes the cycle after full deasserts.
- Full test uses registered full. A pop and a blocked push in the same cycle gives a one-cycle bubble, with no capture that cycle.
- Egress:
  - cmd is driven combinationally from mem[rd_ptr].
  - cmd_rdy = (count != 0), registered.
  - Latency from capture into an empty queue to cmd_rdy=1 is 1 cycle.
- Pop: clr_cmd_rdy && cmd_rdy increments rd_ptr. clr_cmd_rdy while empty is ignored; count never underflows.
- Simultaneous push and pop: count unchanged, both pointers advance, cmd shows the next entry.
- count is updated as count + push - pop. It never exceeds DEPTH; full and cmd_rdy are derived from the next-state count.
- Ordering is strict FIFO; no command is reordered or dropped.
- Reset mid-handshake: FSM returns to IDLE and queued commands are lost. If UART_wrapper still holds in_rdy after reset, the pending command is captured afresh.

Optional Feature:
- Macro: CMD_FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit). When flush=1, count, pointers and cmd_rdy go to 0 on the next edge.
  - A push in that same cycle is discarded, but its ACK pulse is still issued so UART_wrapper is released.
  - flush has priority over pop.
- Undefined: no flush port; queue is emptied only by pops or rst.

Test Plan:
- Reset then single push: in_cmd=16'h2000, in_rdy=1 -> in_clr pulses 1 cycle; cmd_rdy=1 one cycle after capture, cmd=16'h2000, count=1. Pulse clr_cmd_rdy -> cmd_rdy=0, count=0.
- Fill to DEPTH=4 with 16'h4001, 16'h4002, 16'h4003, 16'h4004 and no pops -> full=1, count=4. A fifth in_rdy=1 with 16'h5005 gets no in_clr while full. One pop -> 16'h5005 captured after the bubble, count=4. Drain order is 4002, 4003, 4004, 5005 after the first pop returns 4001.
- in_rdy held high 6 cycles after in_clr (slow UART_wrapper) -> exactly one entry written, count=1.
- Simultaneous push and pop with count=2 -> count stays 2, cmd advances to the next entry. Run 10 pushes through depth 4 to exercise pointer wrap; all 10 values are read back in order.
- Async rst asserted mid-ACK with count=3 -> outputs 0 immediately (cmd_rdy=0, in_clr=0, count=0); clr_cmd_rdy pulses while empty leave count=0.
- With CMD_FIFO_FLUSH_EN, count=3 and flush=1 together with a pop -> count=0 and cmd_rdy=0 next cycle. A subsequent push of 16'h4005 gives cmd=16'h4005.
